// File: rtl/ex_muldiv.sv
// Iterative radix-2 multiply/divide unit with architectural HI/LO registers.
// Optional MULDIV_FAST_MUL_EN: single-cycle array multiplier for MULT/MULTU.
module ex_muldiv #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   prod_q, prod_d;
    logic [WIDTH-1:0]     opnd_q, opnd_d;
    logic                 is_div_q, is_div_d;
    logic                 sneg_q, sneg_d;
    logic                 rneg_q, rneg_d;
    logic                 bz_q, bz_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic                 done_q, done_d;

    logic                 a_neg, b_neg;
    logic [WIDTH-1:0]     a_mag, b_mag;
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_next;
    logic [WIDTH:0]       div_shift;
    logic [WIDTH:0]       div_diff;
    logic [2*WIDTH-1:0]   div_next;
    logic [2*WIDTH-1:0]   res_prod;
    logic [WIDTH-1:0]     quo, rem;
    logic [WIDTH-1:0]     res_hi, res_lo;

    // Signed ops iterate on magnitudes; signs are reapplied in FIN.
    assign a_neg = ~op[0] & src_a[WIDTH-1];
    assign b_neg = ~op[0] & src_b[WIDTH-1];
    assign a_mag = a_neg ? -src_a : src_a;
    assign b_mag = b_neg ? -src_b : src_b;

    // Shift-add: multiplier sits in the low half and drains out the bottom.
    assign mul_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]}
                    + (prod_q[0] ? {1'b0, opnd_q} : '0);
    assign mul_next = {mul_sum, prod_q[WIDTH-1:1]};

    // Restoring divide: remainder in the high half, quotient bits fill low half.
    assign div_shift = prod_q[2*WIDTH-1:WIDTH-1];
    assign div_diff  = div_shift - {1'b0, opnd_q};
    assign div_next  = div_diff[WIDTH]
                     ? {div_shift[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b0}
                     : {div_diff[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b1};

    assign res_prod = sneg_q ? -prod_q : prod_q;
    assign quo      = prod_q[WIDTH-1:0];
    assign rem      = prod_q[2*WIDTH-1:WIDTH];

    always_comb begin
        res_hi = res_prod[2*WIDTH-1:WIDTH];
        res_lo = res_prod[WIDTH-1:0];
        if (is_div_q) begin
            res_hi = rneg_q ? -rem : rem;
            res_lo = bz_q ? '1 : (sneg_q ? -quo : quo);
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        prod_d   = prod_q;
        opnd_d   = opnd_q;
        is_div_d = is_div_q;
        sneg_d   = sneg_q;
        rneg_d   = rneg_q;
        bz_d     = bz_q;
        done_d   = 1'b0;
        hi_d     = hi_we ? wdata : hi_q;
        lo_d     = lo_we ? wdata : lo_q;

        unique case (state_q)
            IDLE: begin
                if (start && !flush) begin
                    is_div_d = op[1];
                    sneg_d   = ~op[0] & (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
                    rneg_d   = a_neg;
                    bz_d     = (src_b == '0);
                    cnt_d    = CNT_W'(WIDTH);
                    state_d  = CALC;
                    if (op[1]) begin
                        opnd_d = b_mag;
                        prod_d = {{WIDTH{1'b0}}, a_mag};
                    end else begin
                        opnd_d = a_mag;
                        prod_d = {{WIDTH{1'b0}}, b_mag};
`ifdef MULDIV_FAST_MUL_EN
                        prod_d  = {{WIDTH{1'b0}}, a_mag}
                                * {{WIDTH{1'b0}}, b_mag};
                        state_d = FIN;
`endif
                    end
                end
            end
            CALC: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    prod_d = is_div_q ? div_next : mul_next;
                    cnt_d  = cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = FIN;
                    end
                end
            end
            FIN: begin
                state_d = IDLE;
                if (!flush) begin
                    hi_d   = res_hi;
                    lo_d   = res_lo;
                    done_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            prod_q   <= '0;
            opnd_q   <= '0;
            is_div_q <= 1'b0;
            sneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            bz_q     <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            prod_q   <= prod_d;
            opnd_q   <= opnd_d;
            is_div_q <= is_div_d;
            sneg_q   <= sneg_d;
            rneg_q   <= rneg_d;
            bz_q     <= bz_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Testbench for ex_muldiv: directed vector table, hand sequences for
// flush/reset/MT* corners, and random ops against an arithmetic model.
module tb_ex_muldiv;

    localparam int W = 32;
`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = W + 1;
`endif
    localparam int DIV_LAT = W + 1;

    logic          clk;
    logic          reset;
    logic          flush;
    logic          start;
    logic [1:0]    op;
    logic [W-1:0]  src_a;
    logic [W-1:0]  src_b;
    logic          hi_we;
    logic          lo_we;
    logic [W-1:0]  wdata;
    logic          busy;
    logic          done;
    logic [W-1:0]  hi;
    logic [W-1:0]  lo;

    int n_pass;
    int n_total;

    ex_muldiv #(.WIDTH(W), .CNT_W(6)) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .start (start),
        .op    (op),
        .src_a (src_a),
        .src_b (src_b),
        .hi_we (hi_we),
        .lo_we (lo_we),
        .wdata (wdata),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
    } vec_t;

    task automatic chk(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Architectural result from plain arithmetic on 64-bit values.
    function automatic void ref_model(input logic [1:0] o,
                                      input logic [W-1:0] a,
                                      input logic [W-1:0] b,
                                      output logic [W-1:0] h,
                                      output logic [W-1:0] l);
        longint     sa, sb, sq, sr;
        logic [63:0] ua, ub, up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        h = '0;
        l = '0;
        case (o)
            2'd0: begin up = 64'(sa * sb); h = up[63:32]; l = up[31:0]; end
            2'd1: begin up = ua * ub; h = up[63:32]; l = up[31:0]; end
            2'd2: begin
                if (b == '0) begin h = a; l = '1; end
                else begin
                    sq = sa / sb; sr = sa % sb;
                    up = 64'(sq); l = up[31:0];
                    up = 64'(sr); h = up[31:0];
                end
            end
            default: begin
                if (b == '0) begin h = a; l = '1; end
                else begin
                    up = ua / ub; l = up[31:0];
                    up = ua % ub; h = up[31:0];
                end
            end
        endcase
    endfunction

    // bsa: cycle after start at which to inject an ignored start (0 = none).
    // we_fin: pulse lo_we with junk data on the result edge.
    task automatic run_op(input logic [1:0] o, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] eh,
                          input logic [W-1:0] el, input string tag,
                          input int bsa, input bit we_fin);
        int lat, exp_lat;
        bit seen;
        exp_lat = o[1] ? DIV_LAT : MUL_LAT;
        @(negedge clk);
        start = 1'b1; op = o; src_a = a; src_b = b;
        @(posedge clk); #1;
        start = 1'b0;
        chk({tag, " busy"}, W'(busy), W'(1));
        lat = 0;
        seen = 1'b0;
        lo_we = we_fin && (exp_lat == 1);
        wdata = 32'hDEAD_0000;
        while (!seen && lat < 200) begin
            @(posedge clk); #1;
            lat++;
            start = 1'b0;
            lo_we = 1'b0;
            if (done) seen = 1'b1;
            else begin
                if (bsa != 0 && lat == bsa) begin
                    start = 1'b1; op = 2'd1; src_a = 9; src_b = 9;
                end
                lo_we = we_fin && (lat == exp_lat - 1);
            end
        end
        start = 1'b0;
        lo_we = 1'b0;
        chk({tag, " lat"}, W'(lat), W'(exp_lat));
        chk({tag, " busy@done"}, W'(busy), W'(0));
        chk({tag, " hi"}, hi, eh);
        chk({tag, " lo"}, lo, el);
        @(posedge clk); #1;
        chk({tag, " done pulse"}, W'(done), W'(0));
    endtask

    vec_t vt[10];

    initial begin
        logic [1:0]   ro;
        logic [W-1:0] ra, rb, eh, el;
        int ndone;

        n_pass = 0;
        n_total = 0;
        reset = 1'b1; flush = 1'b0; start = 1'b0; op = '0;
        src_a = '0; src_b = '0; hi_we = 1'b0; lo_we = 1'b0; wdata = '0;

        vt[0] = '{2'd1, 32'hFFFFFFFF, 32'h2, 32'h1, 32'hFFFFFFFE};
        vt[1] = '{2'd0, 32'hFFFFFFFD, 32'h7, 32'hFFFFFFFF, 32'hFFFFFFEB};
        vt[2] = '{2'd2, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vt[3] = '{2'd3, 32'd100, 32'h0, 32'd100, 32'hFFFFFFFF};
        vt[4] = '{2'd2, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000};
        vt[5] = '{2'd3, 32'd10, 32'd3, 32'd1, 32'd3};
        vt[6] = '{2'd2, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD};
        vt[7] = '{2'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0};
        vt[8] = '{2'd2, 32'hFFFFFFFB, 32'h0, 32'hFFFFFFFB, 32'hFFFFFFFF};
        vt[9] = '{2'd1, 32'h0, 32'h12345, 32'h0, 32'h0};

        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk("reset busy", W'(busy), W'(0));
        chk("reset done", W'(done), W'(0));
        chk("reset hi", hi, 32'h0);
        chk("reset lo", lo, 32'h0);

        lo_we = 1'b1; wdata = 32'h1234;
        @(posedge clk); #1 lo_we = 1'b0;
        chk("mtlo lo", lo, 32'h1234);
        chk("mtlo hi", hi, 32'h0);

        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hCAFE0001;
        @(posedge clk); #1 hi_we = 1'b0; lo_we = 1'b0;
        chk("mt both hi", hi, 32'hCAFE0001);
        chk("mt both lo", lo, 32'hCAFE0001);

        // DIVU 10/3 flushed at cycle 5; a stray start at cycle 2 is ignored.
        start = 1'b1; op = 2'd3; src_a = 10; src_b = 3;
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk); #1 start = 1'b1; op = 2'd1; src_a = 5; src_b = 5;
        @(posedge clk); #1 start = 1'b0;
        repeat (2) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        chk("flush busy", W'(busy), W'(0));
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        chk("flush no done", W'(ndone), W'(0));
        chk("flush hi", hi, 32'hCAFE0001);
        chk("flush lo", lo, 32'hCAFE0001);

        start = 1'b1; flush = 1'b1; op = 2'd1; src_a = 3; src_b = 3;
        @(posedge clk); #1 start = 1'b0; flush = 1'b0;
        chk("flush+start busy", W'(busy), W'(0));

        for (int i = 0; i < 10; i++) begin
            run_op(vt[i].op, vt[i].a, vt[i].b, vt[i].hi, vt[i].lo,
                   $sformatf("vec%0d", i), 0, 1'b0);
        end

        run_op(2'd3, 32'd100, 32'd7, 32'd2, 32'd14, "busy start", 3, 1'b0);
        run_op(2'd1, 32'd3, 32'd4, 32'd0, 32'd12, "lo_we fin", 0, 1'b1);

        for (int i = 0; i < 40; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = '0;
                1: begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
                2: rb = W'($urandom_range(1, 15));
                default: ;
            endcase
            ref_model(ro, ra, rb, eh, el);
            run_op(ro, ra, rb, eh, el, $sformatf("rnd%0d", i), 0, 1'b0);
        end

        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hFFFF;
        @(posedge clk); #1 hi_we = 1'b0; lo_we = 1'b0;
        start = 1'b1; op = 2'd2; src_a = 50; src_b = 5;
        @(posedge clk); #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        chk("midreset busy", W'(busy), W'(0));
        chk("midreset done", W'(done), W'(0));
        chk("midreset hi", hi, 32'h0);
        chk("midreset lo", lo, 32'h0);
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        chk("midreset no done", W'(ndone), W'(0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
